idx_scatter: RTL and testbench

Sequential unpacker for the compacted 4-entry index lists produced by the index-merge stage. It accepts one packed list (count plus up to four indices) over a valid/ready handshake and replays the entries one per cycle on a second valid/ready stream. Each index's MSB is its half-select. While replaying, it rebuilds the per-half counts (the two counts that were merged) and a one-hot occupancy mask of all emitted indices. It sits on the consumer side of the merge tree and feeds the per-index processing lanes.

---
 rtl/idx_scatter_pkg.sv | 22 ++
 rtl/idx_scatter_if.sv | 39 +++
 rtl/idx_scatter_onehot.sv | 14 +
 rtl/idx_scatter.sv | 95 +++++++++
 tb/tb_idx_scatter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/idx_scatter_pkg.sv
// idx_scatter shared types: FSM state encoding, entry limit, count width.
// clip_num saturates a raw 3-bit count to the entry limit.
package idx_scatter_pkg;

  localparam int MAX_ENTRIES = 4;
  localparam int CNT_W       = 3;
  localparam int PTR_W       = $clog2(MAX_ENTRIES);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic cnt_t clip_num(input cnt_t n);
    return (n > cnt_t'(MAX_ENTRIES)) ? cnt_t'(MAX_ENTRIES) : n;
  endfunction

endpackage

// File: rtl/idx_scatter_if.sv
// idx_scatter bus: packed-list input stream, per-entry output stream, summary.
// master = list producer / entry consumer, slave = idx_scatter.
interface idx_scatter_if #(
  parameter int WIDTH = 4
);
  import idx_scatter_pkg::*;

  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_idx1;
  logic [WIDTH-1:0]   i_idx2;
  logic [WIDTH-1:0]   i_idx3;
  logic [WIDTH-1:0]   i_idx4;
  cnt_t               i_num;
  logic               o_valid;
  logic               i_ready;
  logic [WIDTH-1:0]   o_idx;
  logic               o_half;
  logic               o_last;
  logic               o_done;
  cnt_t               o_num_lo;
  cnt_t               o_num_hi;
  logic [2**WIDTH-1:0] o_mask;

  modport master (
    output i_valid, i_idx1, i_idx2, i_idx3, i_idx4,
    output i_num, i_ready,
    input  o_ready, o_valid, o_idx, o_half, o_last,
    input  o_done, o_num_lo, o_num_hi, o_mask
  );

  modport slave (
    input  i_valid, i_idx1, i_idx2, i_idx3, i_idx4,
    input  i_num, i_ready,
    output o_ready, o_valid, o_idx, o_half, o_last,
    output o_done, o_num_lo, o_num_hi, o_mask
  );

endinterface

// File: rtl/idx_scatter_onehot.sv
// idx_onehot: WIDTH-bit index to 2**WIDTH one-hot decoder.
// Ports: idx_i index in, onehot_o decoded bit vector out.
module idx_onehot #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]    idx_i,
  output logic [2**WIDTH-1:0] onehot_o
);

  localparam logic [2**WIDTH-1:0] ONE = {{(2**WIDTH-1){1'b0}}, 1'b1};

  assign onehot_o = ONE << idx_i;

endmodule

// File: rtl/idx_scatter.sv
// idx_scatter: replays a packed 4-entry index list one entry per cycle,
// rebuilding per-half counts and occupancy mask. Ports: i_clk, i_rst_n, bus.
module idx_scatter
  import idx_scatter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  idx_scatter_if.slave bus
);

  state_e              state_q;
  logic [WIDTH-1:0]    ent_q [MAX_ENTRIES];
  cnt_t                n_q;
  ptr_t                ptr_q;
  logic [2**WIDTH-1:0] mask_q;
  logic [2**WIDTH-1:0] mask_d;
  logic [2**WIDTH-1:0] oh;
  cnt_t                lo_q;
  cnt_t                hi_q;
  cnt_t                n_d;
  logic                emit;
  logic                last;
  logic [WIDTH-1:0]    cur_idx;

  assign emit    = (state_q == ST_EMIT);
  assign cur_idx = emit ? ent_q[ptr_q] : '0;
  assign last    = emit &&
                   ({1'b0, ptr_q} == n_q - cnt_t'(1));
  assign n_d     = clip_num(bus.i_num);
  assign mask_d  = mask_q | oh;

  idx_onehot #(
    .WIDTH (WIDTH)
  ) u_onehot (
    .idx_i    (cur_idx),
    .onehot_o (oh)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < MAX_ENTRIES; i++)
        ent_q[i] <= '0;
      n_q     <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_valid) begin
            ent_q[0] <= bus.i_idx1;
            ent_q[1] <= bus.i_idx2;
            ent_q[2] <= bus.i_idx3;
            ent_q[3] <= bus.i_idx4;
            n_q      <= n_d;
            ptr_q    <= '0;
            mask_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            state_q  <= (n_d == '0) ? ST_DONE : ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.i_ready) begin
            mask_q <= mask_d;
            if (cur_idx[WIDTH-1])
              hi_q <= hi_q + cnt_t'(1);
            else
              lo_q <= lo_q + cnt_t'(1);
            ptr_q <= ptr_q + ptr_t'(1);
            if (last)
              state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = (state_q == ST_IDLE);
  assign bus.o_valid  = emit;
  assign bus.o_idx    = cur_idx;
  assign bus.o_half   = cur_idx[WIDTH-1];
  assign bus.o_last   = last;
  assign bus.o_done   = (state_q == ST_DONE);
  assign bus.o_num_lo = lo_q;
  assign bus.o_num_hi = hi_q;
  assign bus.o_mask   = mask_q;

endmodule

// File: tb/tb_idx_scatter.sv
// tb_idx_scatter: directed self-checking bench for idx_scatter.
// Immediate assertions at each check; summary line at end.
module tb_idx_scatter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   cyc;
  int   last_pos;
  int   last_cnt;
  int   done_seen;
  logic [3:0] got_q [$];

  idx_scatter_if #(.WIDTH(4)) bus ();

  idx_scatter #(.WIDTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d,
                      input logic [2:0] n, input bit keep);
    int w;
    w = 0;
    while (!bus.o_ready && w < 10) begin
      step();
      w++;
    end
    check("send_ready", {31'd0, bus.o_ready}, 32'd1);
    bus.i_idx1  = a;
    bus.i_idx2  = b;
    bus.i_idx3  = c;
    bus.i_idx4  = d;
    bus.i_num   = n;
    bus.i_valid = 1'b1;
    step();
    if (!keep) bus.i_valid = 1'b0;
  endtask

  // Collect entries until o_done; cyc = cycles from start to o_done.
  task automatic drain();
    got_q.delete();
    cyc      = 0;
    last_pos = -1;
    last_cnt = 0;
    while (!bus.o_done && cyc < 20) begin
      if (bus.o_valid && bus.i_ready) begin
        if (bus.o_last) begin
          last_pos = got_q.size();
          last_cnt++;
        end
        got_q.push_back(bus.o_idx);
      end
      step();
      cyc++;
    end
    check("done_reached", {31'd0, bus.o_done}, 32'd1);
  endtask

  task automatic summary(input string tag, input logic [15:0] m,
                         input int lo, input int hi);
    check({tag, "_mask"}, {16'd0, bus.o_mask}, {16'd0, m});
    check({tag, "_lo"}, {29'd0, bus.o_num_lo}, lo);
    check({tag, "_hi"}, {29'd0, bus.o_num_hi}, hi);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_idx1  = '0;
    bus.i_idx2  = '0;
    bus.i_idx3  = '0;
    bus.i_idx4  = '0;
    bus.i_num   = '0;
    step();
    step();

    check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_idx", {28'd0, bus.o_idx}, 32'd0);
    check("rst_half", {31'd0, bus.o_half}, 32'd0);
    check("rst_last", {31'd0, bus.o_last}, 32'd0);
    check("rst_done", {31'd0, bus.o_done}, 32'd0);
    summary("rst", 16'h0000, 0, 0);
    rst_n = 1'b1;
    step();

    // Normal list 2,9,5
    send(4'd2, 4'd9, 4'd5, 4'd0, 3'd3, 1'b0);
    check("n1_first_valid", {31'd0, bus.o_valid}, 32'd1);
    check("n1_first_idx", {28'd0, bus.o_idx}, 32'd2);
    check("n1_ready_low", {31'd0, bus.o_ready}, 32'd0);
    drain();
    check("n1_cycles", cyc, 3);
    check("n1_count", got_q.size(), 3);
    check("n1_e0", {28'd0, got_q[0]}, 32'd2);
    check("n1_e1", {28'd0, got_q[1]}, 32'd9);
    check("n1_e2", {28'd0, got_q[2]}, 32'd5);
    check("n1_last_pos", last_pos, 2);
    check("n1_last_cnt", last_cnt, 1);
    summary("n1", 16'h0224, 2, 1);
    check("n1_done_idx", {28'd0, bus.o_idx}, 32'd0);
    step();
    check("n1_idle_ready", {31'd0, bus.o_ready}, 32'd1);
    check("n1_done_pulse", {31'd0, bus.o_done}, 32'd0);
    summary("n1_hold", 16'h0224, 2, 1);

    // Empty list
    send(4'd7, 4'd7, 4'd7, 4'd7, 3'd0, 1'b0);
    drain();
    check("n0_cycles", cyc, 0);
    check("n0_count", got_q.size(), 0);
    summary("n0", 16'h0000, 0, 0);
    step();

    // Clipped count 7 -> 4
    send(4'd0, 4'd1, 4'd2, 4'd3, 3'd7, 1'b0);
    drain();
    check("n7_count", got_q.size(), 4);
    check("n7_e3", {28'd0, got_q[3]}, 32'd3);
    check("n7_last_pos", last_pos, 3);
    summary("n7", 16'h000F, 4, 0);
    step();

    // Duplicates 12,12,3,12
    send(4'd12, 4'd12, 4'd3, 4'd12, 3'd4, 1'b0);
    check("dup_half", {31'd0, bus.o_half}, 32'd1);
    drain();
    check("dup_count", got_q.size(), 4);
    summary("dup", 16'h1008, 1, 3);
    step();

    // Backpressure on the second entry
    send(4'd1, 4'd10, 4'd6, 4'd15, 3'd4, 1'b0);
    check("bp_e0", {28'd0, bus.o_idx}, 32'd1);
    step();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, bus.o_valid}, 32'd1);
      check("bp_idx", {28'd0, bus.o_idx}, 32'd10);
      check("bp_last", {31'd0, bus.o_last}, 32'd0);
      step();
    end
    check("bp_mask_stall", {16'd0, bus.o_mask}, 32'h0002);
    bus.i_ready = 1'b1;
    drain();
    check("bp_count", got_q.size(), 3);
    check("bp_e1", {28'd0, got_q[0]}, 32'd10);
    check("bp_e2", {28'd0, got_q[1]}, 32'd6);
    check("bp_e3", {28'd0, got_q[2]}, 32'd15);
    summary("bp", 16'h8442, 2, 2);
    step();

    // Reset during EMIT
    send(4'd3, 4'd4, 4'd5, 4'd6, 3'd4, 1'b0);
    step();
    check("rm_idx", {28'd0, bus.o_idx}, 32'd4);
    check("rm_mask_pre", {16'd0, bus.o_mask}, 32'h0008);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rm_ready", {31'd0, bus.o_ready}, 32'd1);
    check("rm_idx0", {28'd0, bus.o_idx}, 32'd0);
    summary("rm", 16'h0000, 0, 0);
    step();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_done) done_seen++;
      step();
    end
    check("rm_no_done", done_seen, 0);
    check("rm_ready_after", {31'd0, bus.o_ready}, 32'd1);
    send(4'd8, 4'd13, 4'd0, 4'd0, 3'd2, 1'b0);
    drain();
    check("rm_next_count", got_q.size(), 2);
    summary("rm_next", 16'h2100, 0, 2);
    step();

    // Back-to-back with i_valid held
    send(4'd1, 4'd2, 4'd0, 4'd0, 3'd2, 1'b1);
    bus.i_idx1 = 4'd14;
    bus.i_idx2 = 4'd0;
    bus.i_idx3 = 4'd9;
    bus.i_idx4 = 4'd0;
    bus.i_num  = 3'd3;
    drain();
    check("bb_a_count", got_q.size(), 2);
    check("bb_a_e1", {28'd0, got_q[1]}, 32'd2);
    summary("bb_a", 16'h0006, 2, 0);
    check("bb_done_ready", {31'd0, bus.o_ready}, 32'd0);
    step();
    check("bb_idle_ready", {31'd0, bus.o_ready}, 32'd1);
    check("bb_idle_valid", {31'd0, bus.o_valid}, 32'd0);
    step();
    bus.i_valid = 1'b0;
    check("bb_b_valid", {31'd0, bus.o_valid}, 32'd1);
    check("bb_b_idx", {28'd0, bus.o_idx}, 32'd14);
    summary("bb_b_clr", 16'h0000, 0, 0);
    drain();
    check("bb_b_count", got_q.size(), 3);
    summary("bb_b", 16'h4201, 1, 2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
